// File: rtl/cr_cg_ob_egress_buf.sv
// Egress buffer at the receiving end of the CG outbound AXI4-S path.
// The FIFO presents beats first-word-fall-through and drives a hysteretic external ready.
package cr_cg_ob_egress_buf_pkg;
  typedef struct packed {
    logic        tvalid;
    logic        tlast;
    logic [7:0]  tid;
    logic [7:0]  tstrb;
    logic [7:0]  tuser;
    logic [63:0] tdata;
  } axi4s_dp_bus_t;

  typedef struct packed {
    logic tready;
  } axi4s_dp_rdy_t;

  // Stored payload is everything except tvalid.
  localparam int ENTRY_W = $bits(axi4s_dp_bus_t) - 1;
endpackage

module cr_cg_ob_egress_buf
  import cr_cg_ob_egress_buf_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int HI_WM = 6,
  parameter int LO_WM = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  axi4s_dp_bus_t            cg_ob_out,
  output axi4s_dp_rdy_t            cg_ob_in,
  output axi4s_dp_bus_t            eb_ob_out,
  input  axi4s_dp_rdy_t            eb_ob_in,
  output axi4s_dp_rdy_t            ext_ib_rdy,
  output logic                     eb_frame_done,
  output logic                     eb_stall,
  output logic [$clog2(DEPTH):0]   eb_occ
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  typedef enum logic {RDY = 1'b0, HOLD = 1'b1} ext_state_t;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] head_entry;
  logic [ENTRY_W-1:0] wr_entry;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          in_rdy_q, in_rdy_d;
  logic          frame_done_q, frame_done_d;
  logic          stall_q, stall_d;
  ext_state_t    ext_state_q, ext_state_d;

  logic push;
  logic pop;
  logic not_empty;

  assign not_empty  = (occ_q != '0);
  assign push       = cg_ob_out.tvalid & in_rdy_q;
  assign pop        = not_empty & eb_ob_in.tready;
  assign wr_entry   = {cg_ob_out.tlast, cg_ob_out.tid, cg_ob_out.tstrb,
                       cg_ob_out.tuser, cg_ob_out.tdata};
  assign head_entry = mem_q[rd_ptr_q];

  // Storage carries no reset; the occupancy counter alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q + AW'(push);
    rd_ptr_d     = rd_ptr_q + AW'(pop);
    occ_d        = occ_q + OW'(push) - OW'(pop);
    in_rdy_d     = (occ_d < OW'(DEPTH));
    frame_done_d = pop & head_entry[ENTRY_W-1];
    stall_d      = not_empty & ~eb_ob_in.tready;
  end

  // Hysteresis: only crossing a watermark changes the external ready.
  always_comb begin
    ext_state_d = ext_state_q;
    case (ext_state_q)
      RDY:     if (occ_d >= OW'(HI_WM)) ext_state_d = HOLD;
      HOLD:    if (occ_d <= OW'(LO_WM)) ext_state_d = RDY;
      default: ext_state_d = HOLD;
    endcase
  end

  // Resetting into HOLD makes ext ready rise on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      in_rdy_q     <= 1'b0;
      frame_done_q <= 1'b0;
      stall_q      <= 1'b0;
      ext_state_q  <= HOLD;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      in_rdy_q     <= in_rdy_d;
      frame_done_q <= frame_done_d;
      stall_q      <= stall_d;
      ext_state_q  <= ext_state_d;
    end
  end

  always_comb begin
    eb_ob_out = '0;
    if (not_empty) begin
      eb_ob_out.tvalid = 1'b1;
      {eb_ob_out.tlast, eb_ob_out.tid, eb_ob_out.tstrb,
       eb_ob_out.tuser, eb_ob_out.tdata} = head_entry;
    end
  end

  assign cg_ob_in.tready   = in_rdy_q;
  assign ext_ib_rdy.tready = (ext_state_q == RDY);
  assign eb_frame_done     = frame_done_q;
  assign eb_stall          = stall_q;
  assign eb_occ            = occ_q;

endmodule

// File: tb/tb_cr_cg_ob_egress_buf.sv
// Directed bench for cr_cg_ob_egress_buf: fill, drain, streaming, wrap and mid-frame reset.
module tb_cr_cg_ob_egress_buf;
  import cr_cg_ob_egress_buf_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  axi4s_dp_bus_t cg_ob_out;
  axi4s_dp_rdy_t cg_ob_in;
  axi4s_dp_bus_t eb_ob_out;
  axi4s_dp_rdy_t eb_ob_in;
  axi4s_dp_rdy_t ext_ib_rdy;
  logic          eb_frame_done;
  logic          eb_stall;
  logic [3:0]    eb_occ;

  int errors = 0;
  int checks = 0;

  cr_cg_ob_egress_buf #(.DEPTH(8), .HI_WM(6), .LO_WM(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cg_ob_out    (cg_ob_out),
    .cg_ob_in     (cg_ob_in),
    .eb_ob_out    (eb_ob_out),
    .eb_ob_in     (eb_ob_in),
    .ext_ib_rdy   (ext_ib_rdy),
    .eb_frame_done(eb_frame_done),
    .eb_stall     (eb_stall),
    .eb_occ       (eb_occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_beat(input logic valid, input logic last, input logic [63:0] data);
    cg_ob_out.tvalid = valid;
    cg_ob_out.tlast  = last;
    cg_ob_out.tdata  = data;
    cg_ob_out.tid    = data[7:0] ^ 8'h5A;
    cg_ob_out.tuser  = data[15:8];
    cg_ob_out.tstrb  = 8'hFF;
  endtask

  // Edge, then settle on the falling edge where checks and new drives happen.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    set_beat(1'b0, 1'b0, 64'h0);
    eb_ob_in.tready = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_occ", 64'(eb_occ), 0);
    chk("rst_valid", 64'(eb_ob_out.tvalid), 0);
    chk("rst_cg_rdy", 64'(cg_ob_in.tready), 0);
    chk("rst_ext_rdy", 64'(ext_ib_rdy.tready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel_cg_rdy", 64'(cg_ob_in.tready), 1);
    chk("rel_ext_rdy", 64'(ext_ib_rdy.tready), 1);
    chk("rel_occ", 64'(eb_occ), 0);
    $display("T1 reset release done");

    // Test 1: single beat, 1-cycle latency, frame_done one cycle after pop
    set_beat(1'b1, 1'b1, 64'hA5);
    tick();
    set_beat(1'b0, 1'b0, 64'h0);
    chk("t1_valid", 64'(eb_ob_out.tvalid), 1);
    chk("t1_data", eb_ob_out.tdata, 64'hA5);
    chk("t1_last", 64'(eb_ob_out.tlast), 1);
    chk("t1_tid", 64'(eb_ob_out.tid), 64'hFF);
    chk("t1_tstrb", 64'(eb_ob_out.tstrb), 64'hFF);
    chk("t1_occ", 64'(eb_occ), 1);
    eb_ob_in.tready = 1'b1;
    tick();
    chk("t1_fdone", 64'(eb_frame_done), 1);
    chk("t1_occ0", 64'(eb_occ), 0);
    chk("t1_empty_data", eb_ob_out.tdata, 0);
    tick();
    chk("t1_fdone_pulse", 64'(eb_frame_done), 0);
    $display("T1 single beat tdata=a5");

    // Test 2: fill with downstream stalled
    eb_ob_in.tready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      set_beat(1'b1, (k == 7), 64'h100 + 64'(k));
      chk("t2_cg_rdy_pre", 64'(cg_ob_in.tready), 1);
      tick();
      chk("t2_occ", 64'(eb_occ), 64'(k + 1));
      chk("t2_ext", 64'(ext_ib_rdy.tready), 64'((k + 1) < 6));
      $display("T2 push beat %0d occ=%0d", k, eb_occ);
    end
    chk("t2_cg_rdy_full", 64'(cg_ob_in.tready), 0);
    set_beat(1'b1, 1'b0, 64'h108);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("t2_occ_hold", 64'(eb_occ), 8);
      chk("t2_cg_rdy_hold", 64'(cg_ob_in.tready), 0);
      chk("t2_stall", 64'(eb_stall), 1);
      chk("t2_head_stable", eb_ob_out.tdata, 64'h100);
    end
    set_beat(1'b0, 1'b0, 64'h0);

    // Test 3: drain; ext ready rises only at occ<=2
    eb_ob_in.tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_head", eb_ob_out.tdata, 64'h100 + 64'(i));
      chk("t3_last", 64'(eb_ob_out.tlast), 64'(i == 7));
      tick();
      chk("t3_occ", 64'(eb_occ), 64'(7 - i));
      chk("t3_ext", 64'(ext_ib_rdy.tready), 64'((7 - i) <= 2));
      chk("t3_fdone", 64'(eb_frame_done), 64'(i == 7));
      $display("T3 pop beat %0d occ=%0d ext=%0d", i, eb_occ, ext_ib_rdy.tready);
    end
    chk("t3_cg_rdy", 64'(cg_ob_in.tready), 1);

    // Test 4: 100 beats streaming at one per cycle
    for (int i = 0; i < 100; i++) begin
      set_beat(1'b1, 1'b0, 64'h1000 + 64'(i));
      tick();
      chk("t4_occ", 64'(eb_occ), 1);
      chk("t4_head", eb_ob_out.tdata, 64'h1000 + 64'(i));
      chk("t4_stall", 64'(eb_stall), 0);
    end
    set_beat(1'b0, 1'b0, 64'h0);
    tick();
    chk("t4_drained", 64'(eb_occ), 0);
    $display("T4 streamed 100 beats");

    // Test 5: refill to full, then stream through a full buffer across the wrap
    eb_ob_in.tready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      set_beat(1'b1, 1'b0, 64'h200 + 64'(k));
      tick();
    end
    set_beat(1'b0, 1'b0, 64'h0);
    chk("t5_full", 64'(eb_occ), 8);
    eb_ob_in.tready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      set_beat(1'b1, 1'b0, (k == 0) ? 64'h300 : 64'h300 + 64'(k - 1));
      chk("t5_head", eb_ob_out.tdata, (k < 8) ? 64'h200 + 64'(k) : 64'h300 + 64'(k - 8));
      tick();
      chk("t5_occ", 64'(eb_occ), 7);
      chk("t5_cg_rdy", 64'(cg_ob_in.tready), 1);
      $display("T5 cycle %0d head=%0h occ=%0d", k, eb_ob_out.tdata, eb_occ);
    end
    set_beat(1'b0, 1'b0, 64'h0);

    // Test 6: mid-frame reset at occ=5; heads now 0x304.. after 12 cycles above
    tick();
    tick();
    chk("t6_occ5", 64'(eb_occ), 5);
    eb_ob_in.tready = 1'b0;
    tick();
    chk("t6_stall_pre", 64'(eb_stall), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_occ", 64'(eb_occ), 0);
    chk("t6_valid", 64'(eb_ob_out.tvalid), 0);
    chk("t6_data", eb_ob_out.tdata, 0);
    chk("t6_cg_rdy", 64'(cg_ob_in.tready), 0);
    chk("t6_ext", 64'(ext_ib_rdy.tready), 0);
    chk("t6_stall", 64'(eb_stall), 0);
    chk("t6_fdone", 64'(eb_frame_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t6_rel_occ", 64'(eb_occ), 0);
    chk("t6_rel_valid", 64'(eb_ob_out.tvalid), 0);
    chk("t6_rel_cg_rdy", 64'(cg_ob_in.tready), 1);
    set_beat(1'b1, 1'b1, 64'h400);
    tick();
    set_beat(1'b0, 1'b0, 64'h0);
    chk("t6_new_head", eb_ob_out.tdata, 64'h400);
    chk("t6_new_occ", 64'(eb_occ), 1);
    $display("T6 reset mid-frame, new head=%0h", eb_ob_out.tdata);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
